// File: rtl/frame_scanout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scanout_pkg
//  Description : Shared VGA 640x480 timing constants, frame-buffer geometry,
//                the per-pixel sync/blank bundle and the frame-buffer address
//                helper used by the scan-out block and its RAM.
//  Revision    : 1.0  initial release
// ============================================================================
package frame_scanout_pkg;

  // Horizontal timing, in pixel periods
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;

  // Vertical timing, in lines
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_TOTAL      = 10'd525;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;

  // Frame-buffer geometry (each cell is a 4x4 block of screen pixels)
  localparam logic [7:0]  FB_W     = 8'd160;
  localparam logic [6:0]  FB_H     = 7'd120;
  localparam logic [14:0] FB_CELLS = 15'd19200;
  localparam logic [14:0] FB_LAST  = 15'd19199;

  // Sync/blank values travelling down the pipeline alongside the pixel data
  typedef struct packed {
    logic hs;   // active-low horizontal sync
    logic vs;   // active-low vertical sync
    logic vis;  // inside the visible window
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

  // row*160 + col built from shifts: row*128 + row*32 + col
  function automatic logic [14:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    return ({8'd0, row} << 7) + ({8'd0, row} << 5) + {7'd0, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_scanout_fb_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fb_ram
//  Description : 19200 x 3 simple dual-port frame-buffer RAM. One synchronous
//                write port, one registered read port. A read and a write to
//                the same address in the same cycle returns the old contents.
//                Contents are not reset.
//  Ports       : clock        - write/read clock
//                we/waddr/wdata - write port
//                raddr/rdata  - read port, rdata valid one clock after raddr
//  Revision    : 1.0  initial release
// ============================================================================
module fb_ram
  import frame_scanout_pkg::*;
(
  input  logic        clock,
  input  logic        we,
  input  logic [14:0] waddr,
  input  logic [2:0]  wdata,
  input  logic [14:0] raddr,
  output logic [2:0]  rdata
);

  logic [2:0] mem [0:FB_CELLS-1];

  // Both ports in one non-blocking block: the read sees the pre-write value.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/frame_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scanout
//  Description : 160x120x3 frame buffer with a plot write port and 640x480
//                VGA scan-out (each cell shown as a 4x4 pixel block). After
//                reset the whole buffer is swept to BACKGROUND while busy=1.
//  Ports       : clock, resetn                - clock, async active-low reset
//                x, y, colour, plot           - pixel write port
//                busy                         - clear sweep in progress
//                VGA_R/G/B, VGA_HS/VS         - video and active-low syncs
//                VGA_BLANK_N/SYNC_N/CLK       - DAC controls
//  Revision    : 1.0  initial release
// ============================================================================
module frame_scanout
  import frame_scanout_pkg::*;
#(
  parameter logic [2:0] BACKGROUND = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       busy,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]  state;
  logic [14:0] clear_addr;
  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;

  logic        plot_ok;
  logic        we;
  logic [14:0] waddr;
  logic [2:0]  wdata;
  logic [14:0] raddr;
  logic [2:0]  rdata;

  sync_t       sync0;
  sync_t       sync1;
  sync_t       sync2;
  logic [2:0]  pix_q;

  // ---------------- clear sweep ----------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_CLEAR;
      clear_addr <= '0;
    end else if (state == S_CLEAR) begin
      if (clear_addr == FB_LAST) begin
        state <= S_RUN;
      end
      clear_addr <= clear_addr + 15'd1;
    end
  end

  assign busy = (state == S_CLEAR);

  // Out-of-range coordinates are dropped outright rather than wrapped into
  // some other cell.
  assign plot_ok = plot && !busy && (x < FB_W) && (y < FB_H);

  // The clear owns the write port for its whole duration.
  assign we    = busy || plot_ok;
  assign waddr = busy ? clear_addr : fb_addr(y, x);
  assign wdata = busy ? BACKGROUND : colour;

  // ---------------- timing counters ----------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcount == H_TOTAL - 10'd1) begin
          hcount <= '0;
          vcount <= (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  // Stage 0: sync/blank and read address straight from the counters.
  // Outside the visible window the address may land beyond the buffer;
  // the result is blanked so its value never reaches the DAC.
  always_comb begin
    sync0     = SYNC_IDLE;
    sync0.hs  = !((hcount >= H_SYNC_START) && (hcount <= H_SYNC_END));
    sync0.vs  = !((vcount >= V_SYNC_START) && (vcount <= V_SYNC_END));
    sync0.vis = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
  end

  assign raddr = fb_addr(vcount[8:2], hcount[9:2]);

  fb_ram u_fb_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Stage 1 runs in step with the RAM read; stage 2 is the output register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= SYNC_IDLE;
      sync2 <= SYNC_IDLE;
      pix_q <= 3'b000;
    end else begin
      sync1 <= sync0;
      sync2 <= sync1;
      pix_q <= sync1.vis ? rdata : 3'b000;
    end
  end

  assign VGA_R       = {8{pix_q[2]}};
  assign VGA_G       = {8{pix_q[1]}};
  assign VGA_B       = {8{pix_q[0]}};
  assign VGA_HS      = sync2.hs;
  assign VGA_VS      = sync2.vs;
  assign VGA_BLANK_N = sync2.vis;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pix_en;

endmodule
`default_nettype wire

// File: tb/tb_frame_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_scanout
//  Description : Self-checking bench for frame_scanout. A negedge monitor
//                compares every output against a model computed from the
//                clock count since reset release and a 160x120 shadow frame
//                buffer; directed steps cover reset, clear length, plotting,
//                out-of-range writes and a reset pulse mid-clear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_scanout;
  import frame_scanout_pkg::*;

  localparam logic [2:0] BG = 3'b010;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       plot = 1'b0;
  logic       busy;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

  int  nvec = 0;
  int  nbad = 0;
  int  k = 0;          // rising edges since the last reset release
  bit  mon_on = 1'b0;
  bit  check_rgb = 1'b0;
  logic [2:0] model [0:19199];

  frame_scanout #(.BACKGROUND(BG)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_CLK     (VGA_CLK)
  );

  always #10 clock = ~clock;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) k <= 0;
    else         k <= k + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h k=%0d", tag, obs, exp, k);
    end
  endtask

  function automatic logic [23:0] expand(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_hs"},   {31'd0, VGA_HS}, 32'd1);
    check({tag, "_vs"},   {31'd0, VGA_VS}, 32'd1);
    check({tag, "_bn"},   {31'd0, VGA_BLANK_N}, 32'd0);
    check({tag, "_rgb"},  {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check({tag, "_clk"},  {31'd0, VGA_CLK}, 32'd0);
  endtask

  // Screen model: outputs after k edges show the counters as they stood
  // two edges earlier; the pixel counter advances every second edge.
  always @(negedge clock) begin : monitor
    int t, h, v;
    logic ehs, evs, ebn;
    logic [2:0] c;
    if (mon_on) begin
      if (!resetn) begin
        check_reset_outputs("rst");
      end else begin
        check("vga_clk", {31'd0, VGA_CLK}, k % 2);
        if (k < 2) begin
          ehs = 1'b1; evs = 1'b1; ebn = 1'b0; h = 0; v = 0;
        end else begin
          t   = (k - 2) / 2;
          h   = t % 800;
          v   = (t / 800) % 525;
          ehs = !(h >= 656 && h <= 751);
          evs = !(v >= 490 && v <= 491);
          ebn = (h < 640) && (v < 480);
        end
        check("hs",     {31'd0, VGA_HS}, {31'd0, ehs});
        check("vs",     {31'd0, VGA_VS}, {31'd0, evs});
        check("blank_n",{31'd0, VGA_BLANK_N}, {31'd0, ebn});
        check("sync_n", {31'd0, VGA_SYNC_N}, 32'd0);
        if (!ebn) begin
          check("rgb_blank", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        end else if (check_rgb) begin
          c = model[(v / 4) * 160 + h / 4];
          check("rgb_pix", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, expand(c)});
        end
      end
    end
  end

  task automatic do_plot(input int px, input int py, input logic [2:0] pc);
    x      = 8'(px);
    y      = 7'(py);
    colour = pc;
    plot   = 1'b1;
    @(posedge clock);
    #1;
    plot = 1'b0;
    if (px < 160 && py < 120) model[py * 160 + px] = pc;
  endtask

  initial begin
    int cnt;
    int px, py;

    // Reset held: reset values visible
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("init");
    mon_on = 1'b1;

    // Release, then pulse reset with the clear sweep at address 10000
    @(negedge clock);
    #5 resetn = 1'b1;
    repeat (10000) @(posedge clock);
    #1;
    check("mid_clear_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clock);
    @(negedge clock);
    #5 resetn = 1'b1;

    // Full clear length again; plots issued mid-clear must be ignored
    cnt = 0;
    while (busy === 1'b1 && cnt < 20000) begin
      @(posedge clock);
      #1;
      cnt++;
      if (cnt == 5000) begin
        x = 8'd2; y = 7'd3; colour = 3'b111; plot = 1'b1;
      end else if (cnt == 5001) begin
        x = 8'd0; y = 7'd0;
      end else begin
        plot = 1'b0;
      end
    end
    plot = 1'b0;
    check("busy_len", cnt, 32'd19200);

    for (int i = 0; i < 19200; i++) model[i] = BG;

    // Directed plots: one in-range cell, then out-of-range coordinates that
    // would alias into visible cells (row 3 col 40, row 4 col 95) if wrapped
    do_plot(5, 3, 3'b100);
    do_plot(200, 2, 3'b111);
    do_plot(255, 3, 3'b111);
    do_plot(0, 120, 3'b111);
    do_plot(160, 0, 3'b111);
    repeat (3) @(posedge clock);
    #1;
    check_rgb = 1'b1;

    // Random bursts into the rows that scan past within the run
    for (int b = 0; b < 4; b++) begin
      repeat (3200) @(posedge clock);
      #1;
      check_rgb = 1'b0;
      for (int p = 0; p < 6; p++) begin
        px = $urandom_range(0, 199);
        py = ($urandom_range(0, 7) == 0) ? $urandom_range(120, 127) : $urandom_range(3, 5);
        do_plot(px, py, 3'($urandom_range(0, 7)));
      end
      repeat (3) @(posedge clock);
      #1;
      check_rgb = 1'b1;
    end

    repeat (6000) @(posedge clock);
    #1;
    check("final_busy", {31'd0, busy}, 32'd0);
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_scanout.md
FRAME_SCANOUT -- requirements
Module: frame_scanout

Interface
REQ-001 Parameter BACKGROUND, default 3'b000: colour written to every frame-buffer cell during the post-reset clear.
REQ-002 Port clock, input, 1: 50 MHz system clock; all state is clocked on its rising edge.
REQ-003 Port resetn, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-004 Port x, input, 8: write column, valid range 0..159.
REQ-005 Port y, input, 7: write row, valid range 0..119.
REQ-006 Port colour, input, 3: write pixel {R,G,B}.
REQ-007 Port plot, input, 1: write strobe; one cell is written per clock in which plot=1 is accepted.
REQ-008 Port busy, output, 1: high while the post-reset clear is running; plot is ignored while busy=1.
REQ-009 Ports VGA_R, VGA_G, VGA_B, output, 8 each: pixel colour.
REQ-010 Ports VGA_HS, VGA_VS, output, 1 each: active-low syncs.
REQ-011 Ports VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, output, 1 each: DAC controls.

Function
REQ-012 Frame buffer: 19200 cells x 3 bits, address = y*160 + x, 15 bits, computed as (y<<7)+(y<<5)+x.
REQ-013 Write: plot=1, busy=0, x<160, y<120 -> cell written at that edge; x>=160 or y>=120 -> write dropped, no aliasing.
REQ-014 Pixel enable: toggles every clock, giving 25 MHz; VGA_CLK equals the pixel enable.
REQ-015 hcount: 0..799, advances on pixel enable, wraps 799->0; vcount advances when hcount wraps, range 0..524, wraps 524->0.
REQ-016 Sync: VGA_HS=0 for hcount 656..751; VGA_VS=0 for vcount 490..491; otherwise 1.
REQ-017 Visible: hcount<640 and vcount<480; VGA_BLANK_N=1 only when visible; VGA_SYNC_N held at 0.
REQ-018 Scan read address: (vcount>>2)*160 + (hcount>>2); each cell covers a 4x4 block of screen pixels.
REQ-019 Pipeline: counters, then registered memory read, then output register; HS, VS and BLANK_N are delayed by the same 2 clocks so that they align with RGB.
REQ-020 Colour expansion: each colour bit maps to 8'hFF when 1 and 8'h00 when 0; RGB is forced to 0 when blanked.
REQ-021 Same-cycle write and scan read of the same address returns the old data (read-before-write).
REQ-022 Clear FSM states: CLEAR and RUN.
- CLEAR: writes BACKGROUND to address 0..19199, one cell per clock, with busy=1.
- Transition CLEAR->RUN after address 19199; RUN is held until reset.
REQ-023 Scan-out runs in both CLEAR and RUN states; the clear has priority over plot.

Reset
REQ-024 While resetn=0: hcount=0, vcount=0, pixel enable=0, clear address=0, state=CLEAR, busy=1.
REQ-025 While resetn=0, outputs are VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0.
REQ-026 Reset asserted mid-clear or mid-frame aborts immediately; after release, the clear restarts from address 0.
REQ-027 Frame-buffer contents are not reset by the asynchronous reset; only the clear sweep initialises them.

Structure
REQ-028 A shared package holds:
- H_VISIBLE=640, H_TOTAL=800, H_SYNC_START=656, H_SYNC_END=751;
- V_VISIBLE=480, V_TOTAL=525, V_SYNC_START=490, V_SYNC_END=491;
- FB_W=160, FB_H=120, FB_CELLS=19200.
REQ-029 One sub-module, fb_ram: a dual-port 19200x3 RAM with a synchronous write port and a registered read port, inferable as block RAM.

Verification
REQ-030 Reset release -> busy=1 for exactly 19200 clocks then 0; with BACKGROUND=3'b010, every visible pixel shows R=00, G=FF, B=00.
REQ-031 After clear: plot x=5, y=3, colour=3'b100 -> screen pixels hcount 20..23 and vcount 12..15 show R=FF, G=00, B=00; all neighbouring pixels show background.
REQ-032 Plot x=160, y=0 and x=0, y=120 with colour 3'b111 -> no visible change at cells (0,0) or (0,119).
REQ-033 Timing -> HS low for 96 pixel periods per line, line length 1600 clocks, VS low for 2 lines per frame, frame length 525 lines; BLANK_N never 1 outside the visible window.
REQ-034 Plot x=0, y=0 issued during busy=1 -> ignored; cell (0,0) still shows BACKGROUND after the clear completes.
REQ-035 resetn pulsed low at clear address 10000 -> outputs immediately take reset values; after release, busy lasts a full 19200 clocks again.
